// File: rtl/pwm_edge_buffer.sv
// Period-boundary double buffer for one PWM channel's rise/fall edge times.
// New edge pairs are committed only on the last count of the period, so every period is glitch-free.
module pwm_edge_buffer #(
  parameter int WIDTH = 13
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] CYCLE,
  input  logic [WIDTH-1:0] TIME_CNT,
  input  logic [WIDTH-1:0] RISE_IN,
  input  logic [WIDTH-1:0] FALL_IN,
  output logic [WIDTH-1:0] RISE_OUT,
  output logic [WIDTH-1:0] FALL_OUT
);

  logic [WIDTH-1:0] cycle_last;
  logic             load;
  logic [WIDTH-1:0] rise_d, rise_q;
  logic [WIDTH-1:0] fall_d, fall_q;

  // Wraps modulo 2^WIDTH, so CYCLE == 0 matches an all-ones count.
  assign cycle_last = CYCLE - WIDTH'(1);
  assign load       = (TIME_CNT == cycle_last);

  always_comb begin
    rise_d = rise_q;
    fall_d = fall_q;
    if (load) begin
      rise_d = RISE_IN;
      fall_d = FALL_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign RISE_OUT = rise_q;
  assign FALL_OUT = fall_q;

endmodule

// File: tb/tb_pwm_edge_buffer.sv
// Directed bench for pwm_edge_buffer: bench drives the shared time counter and checks
// outputs 1 time unit after each rising edge.
module tb_pwm_edge_buffer;
  localparam int W = 13;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cycle, tcnt, rin, fin;
  logic [W-1:0] rout, fout;
  logic [W-1:0] er, ef;
  int           n_chk = 0;
  int           n_err = 0;

  pwm_edge_buffer #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .CYCLE(cycle), .TIME_CNT(tcnt),
    .RISE_IN(rin), .FALL_IN(fin), .RISE_OUT(rout), .FALL_OUT(fout)
  );

  always #3 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with counter value t; expected pair follows the reset/load/hold rule.
  task automatic step(input logic [W-1:0] t, input string tag);
    logic [W-1:0] last;
    tcnt = t;
    last = W'(cycle - 1);
    if (rst) begin
      er = '0; ef = '0;
    end else if (t == last) begin
      er = rin; ef = fin;
    end
    @(posedge clk); #1;
    chk({tag, "_rise"}, rout, er);
    chk({tag, "_fall"}, fout, ef);
  endtask

  initial begin
    rst = 1'b1; cycle = 13'd4096; tcnt = 13'd4095; rin = 13'd100; fin = 13'd200;

    // Reset held over a load cycle: must read 0
    step(13'd4095, "rst0");
    chk("rst0_const_r", rout, 13'd0);
    chk("rst0_const_f", fout, 13'd0);
    step(13'd4095, "rst1");
    chk("rst1_const_r", rout, 13'd0);
    chk("rst1_const_f", fout, 13'd0);
    rst = 1'b0; rin = 13'd0; fin = 13'd0;

    // Basic load: 100/200 applied mid-period
    for (int t = 0; t < 4096; t++) begin
      if (t == 2000) begin rin = 13'd100; fin = 13'd200; end
      step(W'(t), "basic");
      if (t == 4094) begin
        chk("basic_pre_r", rout, 13'd0);
        chk("basic_pre_f", fout, 13'd0);
      end
    end
    chk("basic_wrap_r", rout, 13'd100);
    chk("basic_wrap_f", fout, 13'd200);

    // Mid-period change: 300/50 must never appear
    for (int t = 0; t < 4096; t++) begin
      if (t == 1000) begin rin = 13'd300; fin = 13'd50; end
      if (t == 4095) begin rin = 13'd7;   fin = 13'd8;  end
      step(W'(t), "mid");
      if (t == 4094) begin
        chk("mid_hold_r", rout, 13'd100);
        chk("mid_hold_f", fout, 13'd200);
      end
    end
    chk("mid_wrap_r", rout, 13'd7);
    chk("mid_wrap_f", fout, 13'd8);

    // Bring outputs back to 100/200
    rin = 13'd100; fin = 13'd200;
    for (int t = 0; t < 4096; t++) step(W'(t), "prep");
    chk("prep_r", rout, 13'd100);
    chk("prep_f", fout, 13'd200);

    // Reset for one cycle mid-period
    for (int t = 0; t < 4096; t++) begin
      if (t == 2000) rst = 1'b1;
      if (t == 2001) rst = 1'b0;
      if (t == 3000) begin rin = 13'd55; fin = 13'd66; end
      step(W'(t), "rstmid");
      if (t == 1999) chk("rstmid_before_r", rout, 13'd100);
      if (t == 2000) chk("rstmid_zero_r", rout, 13'd0);
      if (t == 4094) chk("rstmid_stay0_f", fout, 13'd0);
    end
    chk("rstmid_load_r", rout, 13'd55);
    chk("rstmid_load_f", fout, 13'd66);

    // Small cycle, inputs changing every clock
    cycle = 13'd5;
    for (int p = 0; p < 3; p++) begin
      for (int t = 0; t < 5; t++) begin
        rin = W'(p * 50 + t * 7 + 1);
        fin = W'(1000 - p * 50 - t * 3);
        step(W'(t), "small");
        if (p == 0 && t == 3) chk("small_hold_r", rout, 13'd55);
        if (t == 4) begin
          chk("small_load_r", rout, W'(p * 50 + 29));
          chk("small_load_f", fout, W'(988 - p * 50));
        end
      end
    end

    // Full-range values, then counter held
    cycle = 13'd8191; rin = 13'd8191; fin = 13'd0;
    for (int t = 8180; t < 8191; t++) step(W'(t), "full");
    chk("full_r", rout, 13'd8191);
    chk("full_f", fout, 13'd0);
    rin = 13'd1; fin = 13'd2;
    for (int i = 0; i < 20; i++) step(13'd100, "held");
    chk("held_r", rout, 13'd8191);

    // CYCLE == 0 loads at all-ones count
    cycle = 13'd0; rin = 13'd5; fin = 13'd6;
    step(13'd8190, "c0_nol");
    chk("c0_nol_r", rout, 13'd8191);
    step(13'd8191, "c0_load");
    chk("c0_load_r", rout, 13'd5);
    chk("c0_load_f", fout, 13'd6);

    // Reset and load condition together: reset wins
    cycle = 13'd10; rin = 13'd9; fin = 13'd9; rst = 1'b1;
    step(13'd9, "rstload");
    chk("rstload_r", rout, 13'd0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
